// File: rtl/alu_exec_sequencer_pkg.sv
// Shared sizing, state encoding and length clamp for the ALU execution sequencer.
package alu_exec_sequencer_pkg;

    localparam int ADDR_WIDTH = 10;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0] LEN_MAX = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_RUN   = 2'd1,
        SEQ_DRAIN = 2'd2,
        SEQ_DONE  = 2'd3
    } seq_state_t;

    function automatic logic [ADDR_WIDTH:0] clamp_len(input logic [ADDR_WIDTH:0] len);
        return (len > LEN_MAX) ? LEN_MAX : len;
    endfunction

endpackage

// File: rtl/alu_exec_sequencer_addr_gen.sv
// Window address generator: offset counter over [base, base+len), wrapping modulo DEPTH.
module alu_exec_sequencer_addr_gen
    import alu_exec_sequencer_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load_i,
    input  logic                  inc_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_o
);

    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   off_q;

    // off_q counts reads already issued; element 0 is issued in the load cycle itself.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            base_q <= '0;
            len_q  <= '0;
            off_q  <= '0;
        end else if (load_i) begin
            base_q <= base_i;
            len_q  <= len_i;
            off_q  <= (ADDR_WIDTH + 1)'(1);
        end else if (inc_i) begin
            off_q  <= off_q + (ADDR_WIDTH + 1)'(1);
        end
    end

    assign addr_o = load_i ? base_i : base_q + off_q[ADDR_WIDTH-1:0];
    assign last_o = (off_q == len_q);

endmodule

// File: rtl/alu_exec_sequencer.sv
// Run controller for the A/B/op BRAM + ALU + output BRAM datapath; owns the BRAM
// ports while a run is in flight and reports completion through a start/done handshake.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  SEQ_IDLE  | host owns BRAMs; waits for start_i
//  SEQ_RUN   | one read per cycle across the window
//  SEQ_DRAIN | no read; final pipelined write commits
//  SEQ_DONE  | done_o high until start_i drops
module alu_exec_sequencer
    import alu_exec_sequencer_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic                  eng_sel_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  abort_o,
    output logic [ADDR_WIDTH:0]   proc_cnt_o
);

    seq_state_t            state;
    logic                  aborted;
    logic [ADDR_WIDTH:0]   len_clamped;
    logic                  ag_load;
    logic                  ag_inc;
    logic                  ag_last;
    logic [ADDR_WIDTH-1:0] ag_addr;

    assign len_clamped = clamp_len(len_i);
    assign ag_load     = (state == SEQ_IDLE) && start_i && (len_clamped != '0);
    assign ag_inc      = (state == SEQ_RUN) && !abort_i && !ag_last;

    alu_exec_sequencer_addr_gen u_addr_gen (
        .CLK    (CLK),
        .RST    (RST),
        .load_i (ag_load),
        .inc_i  (ag_inc),
        .base_i (base_addr_i),
        .len_i  (len_clamped),
        .addr_o (ag_addr),
        .last_o (ag_last)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= SEQ_IDLE;
            aborted    <= 1'b0;
            rd_en_o    <= 1'b0;
            rd_addr_o  <= '0;
            wr_en_o    <= 1'b0;
            wr_addr_o  <= '0;
            eng_sel_o  <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            abort_o    <= 1'b0;
            proc_cnt_o <= '0;
        end else begin
            // The ALU is combinational over a 1-cycle read, so each write trails its read by one cycle.
            wr_en_o   <= rd_en_o;
            wr_addr_o <= rd_addr_o;
            abort_o   <= 1'b0;
            if (wr_en_o) begin
                proc_cnt_o <= proc_cnt_o + (ADDR_WIDTH + 1)'(1);
            end

            case (state)
                SEQ_IDLE: begin
                    if (start_i) begin
                        proc_cnt_o <= '0;
                        aborted    <= 1'b0;
                        if (len_clamped == '0) begin
                            state  <= SEQ_DONE;
                            done_o <= 1'b1;
                        end else begin
                            state     <= SEQ_RUN;
                            rd_en_o   <= 1'b1;
                            rd_addr_o <= ag_addr;
                            busy_o    <= 1'b1;
                            eng_sel_o <= 1'b1;
                        end
                    end
                end
                SEQ_RUN: begin
                    if (abort_i || ag_last) begin
                        state   <= SEQ_DRAIN;
                        rd_en_o <= 1'b0;
                        aborted <= abort_i;
                    end else begin
                        rd_en_o   <= 1'b1;
                        rd_addr_o <= ag_addr;
                    end
                end
                SEQ_DRAIN: begin
                    busy_o    <= 1'b0;
                    eng_sel_o <= 1'b0;
                    if (aborted) begin
                        state   <= SEQ_IDLE;
                        abort_o <= 1'b1;
                    end else begin
                        state  <= SEQ_DONE;
                        done_o <= 1'b1;
                    end
                end
                SEQ_DONE: begin
                    if (!start_i) begin
                        state  <= SEQ_IDLE;
                        done_o <= 1'b0;
                    end
                end
                default: begin
                    state <= SEQ_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Scoreboard bench for alu_exec_sequencer: expected read/write addresses are queued by
// the directed tests and consumed by an independent monitor.
module tb_alu_exec_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [9:0]  base_addr_i = '0;
    logic [10:0] len_i = '0;
    logic        rd_en_o;
    logic [9:0]  rd_addr_o;
    logic        wr_en_o;
    logic [9:0]  wr_addr_o;
    logic        eng_sel_o;
    logic        busy_o;
    logic        done_o;
    logic        abort_o;
    logic [10:0] proc_cnt_o;

    int passed = 0;
    int total  = 0;
    int exp_rd[$];
    int exp_wr[$];

    alu_exec_sequencer dut (
        .CLK         (CLK),
        .RST         (RST),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .base_addr_i (base_addr_i),
        .len_i       (len_i),
        .rd_en_o     (rd_en_o),
        .rd_addr_o   (rd_addr_o),
        .wr_en_o     (wr_en_o),
        .wr_addr_o   (wr_addr_o),
        .eng_sel_o   (eng_sel_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .abort_o     (abort_o),
        .proc_cnt_o  (proc_cnt_o)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: every read/write the DUT presents must match the head of its queue.
    always @(negedge CLK) begin
        int e;
        if (RST) begin
            if (rd_en_o) begin
                if (exp_rd.size() == 0) check("unexpected read", 1, 0);
                else begin
                    e = exp_rd.pop_front();
                    check("rd_addr", rd_addr_o, e);
                end
                check("eng_sel on read", eng_sel_o, 1);
            end
            if (wr_en_o) begin
                if (exp_wr.size() == 0) check("unexpected write", 1, 0);
                else begin
                    e = exp_wr.pop_front();
                    check("wr_addr", wr_addr_o, e);
                end
                check("eng_sel on write", eng_sel_o, 1);
            end
        end
    end

    task automatic run_seq(input string name, input int base, input int len,
                           input int abort_at, input int hold, input bit drop_early);
        int  eff;
        int  nrd;
        int  n;
        int  rdn;
        bit  fin;
        eff = (len > 1024) ? 1024 : len;
        nrd = (abort_at > 0 && abort_at < eff) ? abort_at : eff;
        for (int i = 0; i < nrd; i++) begin
            exp_rd.push_back((base + i) % 1024);
            exp_wr.push_back((base + i) % 1024);
        end
        @(negedge CLK);
        base_addr_i = 10'(base);
        len_i       = 11'(len);
        abort_i     = 1'b0;
        start_i     = 1'b1;
        @(posedge CLK);
        n = 0; rdn = 0; fin = 1'b0;
        for (int c = 0; c < 1200 && !fin; c++) begin
            @(negedge CLK);
            n++;
            if (drop_early && n == 1) start_i = 1'b0;
            if (rd_en_o) rdn++;
            abort_i = (abort_at > 0 && rd_en_o && rdn == abort_at);
            if (done_o || abort_o) fin = 1'b1;
        end
        abort_i = 1'b0;
        if (!fin) begin
            check({name, " timeout"}, 0, 1);
            start_i = 1'b0;
            return;
        end
        if (abort_at > 0) begin
            start_i = 1'b0;
            check({name, " abort latency"}, n, abort_at + 2);
            check({name, " done during abort"}, done_o, 0);
            check({name, " proc_cnt"}, proc_cnt_o, nrd);
            @(negedge CLK);
            check({name, " abort one pulse"}, abort_o, 0);
            check({name, " idle after abort"}, {busy_o, done_o, eng_sel_o}, 0);
        end else begin
            check({name, " done latency"}, n, (eff == 0) ? 1 : eff + 2);
            check({name, " proc_cnt"}, proc_cnt_o, eff);
            check({name, " busy at done"}, busy_o, 0);
            for (int h = 0; h < hold; h++) begin
                @(negedge CLK);
                check({name, " done held"}, {done_o, busy_o, rd_en_o}, 3'b100);
            end
            start_i = 1'b0;
            @(negedge CLK);
            check({name, " done cleared"}, done_o, 0);
        end
        check({name, " reads drained"}, exp_rd.size(), 0);
        check({name, " writes drained"}, exp_wr.size(), 0);
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        int rdn;
        #12;
        check("reset outputs", {rd_en_o, wr_en_o, eng_sel_o, busy_o, done_o, abort_o}, 0);
        check("reset proc_cnt", proc_cnt_o, 0);
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        run_seq("full sweep", 0, 1024, 0, 3, 1'b0);
        run_seq("wrap", 1020, 8, 0, 0, 1'b0);
        run_seq("len zero", 77, 0, 0, 2, 1'b0);
        run_seq("abort", 200, 100, 10, 0, 1'b0);
        run_seq("abort on last", 40, 5, 5, 0, 1'b0);
        run_seq("start drop", 500, 4, 0, 0, 1'b1);
        run_seq("clamp", 5, 2000, 0, 6, 1'b0);
        run_seq("retrigger", 3, 3, 0, 0, 1'b0);

        // Asynchronous reset in the middle of a run.
        for (int i = 0; i < 100; i++) begin
            exp_rd.push_back(100 + i);
            exp_wr.push_back(100 + i);
        end
        @(negedge CLK);
        base_addr_i = 10'd100;
        len_i       = 11'd100;
        start_i     = 1'b1;
        rdn = 0;
        for (int c = 0; c < 200 && rdn < 50; c++) begin
            @(negedge CLK);
            if (rd_en_o) rdn++;
        end
        check("reached read 50", rdn, 50);
        #2 RST = 1'b0;
        #1;
        check("async reset outputs", {rd_en_o, wr_en_o, eng_sel_o, busy_o, done_o, abort_o}, 0);
        check("async reset proc_cnt", proc_cnt_o, 0);
        exp_rd.delete();
        exp_wr.delete();
        start_i = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        run_seq("after reset", 1000, 30, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
